load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single core clock.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-003 SHALL have port ld_en, input, 1, load issue permitted (low on flush/hazard).
REQ-004 SHALL have port st_en, input, 1, store issue permitted.
REQ-005 SHALL have port is_load, input, 1, decoded instruction is a load.
REQ-006 SHALL have port is_store, input, 1, decoded instruction is a store.
REQ-007 SHALL have port funct3, input, 3, access size/sign (0 B, 1 H, 2 W, 4 BU, 5 HU).
REQ-008 SHALL have port addr, input, 32, effective byte address.
REQ-009 SHALL have port st_data, input, 32, store source, LSB-aligned.
REQ-010 SHALL have port rd, input, 5, load destination register.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-012 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_req_we out 1, mem_req_addr out 32 (word-aligned), mem_req_wdata out 32, mem_req_be out 4.
REQ-013 SHALL have ports mem_resp_valid in 1, mem_resp_data in 32 (loads only).
REQ-014 SHALL have ports ld_valid out 1, ld_rd out 5, ld_data out 32: one-cycle load writeback.
REQ-015 SHALL have port access_fault, output, 1, one-cycle pulse on misaligned/illegal access.

Function
REQ-016 States: IDLE, REQ, WAIT_RESP, DONE.
REQ-017 Accept in IDLE only, when (is_load & ld_en) | (is_store & st_en); never both is_load and is_store; is_load wins if both.
REQ-018 On accept: register word address addr[31:2]<<2, byte offset, funct3, rd, we; go to REQ next cycle.
REQ-019 Store data replicated to byte lane by offset (SB: byte x4, SH: half x2, SW: as-is); be = 0001<<off (B), 0011<<off (H), 1111 (W).
REQ-020 REQ: mem_req_valid=1, fields held stable until mem_req_ready; handshake = valid & ready.
REQ-021 REQ handshake, store: go to IDLE; no response expected.
REQ-022 REQ handshake, load: go to WAIT_RESP; mem_resp_valid ignored in REQ.
REQ-023 WAIT_RESP & mem_resp_valid: register aligned/extended data, go to DONE.
REQ-024 DONE: ld_valid=1, ld_rd and ld_data valid, exactly one cycle; then IDLE.
REQ-025 Load extraction: byte/half selected by offset; funct3 0/1 sign-extend, 4/5 zero-extend, 2 full word.
REQ-026 Misalignment: H/HU/SH with addr[0]=1, W/SW with addr[1:0]!=0; illegal: load funct3 3/6/7, store funct3 >=3.
REQ-027 Misaligned/illegal accept: no memory request, access_fault=1 next cycle, remain IDLE, busy stays 0.
REQ-028 Minimum load latency: accept cycle N, mem_req_valid N+1, resp N+2 earliest, ld_valid N+3.
REQ-029 ld_en/st_en/is_* ignored while busy; outstanding accesses never cancelled by upstream flush.
REQ-030 ld_data/ld_rd hold last value outside DONE; ld_valid, mem_req_valid, access_fault low outside their states.

Reset
REQ-031 Reset asserted at any time: state IDLE, busy 0, mem_req_valid 0, ld_valid 0, access_fault 0, ld_rd 0, ld_data 0, other mem_req_* 0, mid-flight access dropped.
REQ-032 No request shall issue in the first cycle after reset deassertion.

Structure
REQ-033 State enum and funct3 size encodings SHALL live in the shared core package riscv_pkg.
REQ-034 Load extraction/extension SHALL be the combinational sub-module load_align (offset, funct3, word -> data).

Verification
REQ-035 LW addr 0x100, ready immediate, resp 0xDEADBEEF after 2 waits -> ld_valid one cycle, ld_data 0xDEADBEEF, ld_rd = rd.
REQ-036 LB addr 0x103, resp 0x80FF00FF -> ld_data 0xFFFFFF80; LBU same -> 0x00000080; LHU 0x102 -> 0x000080FF.
REQ-037 SH addr 0x206, st_data 0x1234ABCD -> mem_req_addr 0x204, be 1100, wdata 0xABCDABCD, we 1, no ld_valid.
REQ-038 LW addr 0x101 -> access_fault one cycle, mem_req_valid never high, busy 0.
REQ-039 mem_req_ready low 5 cycles -> mem_req_* stable, busy 1, new is_load ignored; issues after ready.
REQ-040 reset during WAIT_RESP then late mem_resp_valid -> IDLE, ld_valid stays 0.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared core definitions: load/store unit state encoding,
//               funct3 access-size encodings and the access legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   typedef enum logic [1:0] {
      LSU_IDLE      = 2'd0,
      LSU_REQ       = 2'd1,
      LSU_WAIT_RESP = 2'd2,
      LSU_DONE      = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   // High when the access is misaligned or uses an encoding that does not
   // exist for its direction (stores have no unsigned variants).
   function automatic logic access_bad(input logic       is_ld,
                                       input logic [2:0] f3,
                                       input logic [1:0] off);
      logic bad;
      case (f3)
         F3_B:    bad = 1'b0;
         F3_BU:   bad = !is_ld;
         F3_H:    bad = off[0];
         F3_HU:   bad = !is_ld || off[0];
         F3_W:    bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects the addressed byte/half of a returned memory word and
//               sign- or zero-extends it according to funct3.
// Ports       : offset - byte offset within the word
//               funct3 - load size/sign encoding
//               word   - raw word returned by memory
//               data   - aligned, extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
   import riscv_pkg::*;
(
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   input  logic [31:0] word,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (offset)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      // Halfword accesses are 2-byte aligned, so offset[1] picks the half.
      half_sel = offset[1] ? word[31:16] : word[15:0];

      case (funct3)
         F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data = {24'h0, byte_sel};
         F3_H:    data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data = {16'h0, half_sel};
         default: data = word;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit. Accepts one access in
//               IDLE, issues a word-aligned memory request with byte enables,
//               waits for load data and writes it back for one cycle.
//               Misaligned/illegal accesses raise a one-cycle access_fault.
// Ports       : clk, reset (async, active-high)
//               ld_en/st_en/is_load/is_store/funct3/addr/st_data/rd - issue
//               busy                  - unit is not idle
//               mem_req_*             - memory request channel (valid/ready)
//               mem_resp_valid/data   - memory load response
//               ld_valid/ld_rd/ld_data - load writeback
//               access_fault          - misaligned/illegal access pulse
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_en,
   input  logic        st_en,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] st_data,
   input  logic [4:0]  rd,
   output logic        busy,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_be,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        ld_valid,
   output logic [4:0]  ld_rd,
   output logic [31:0] ld_data,
   output logic        access_fault
);

   lsu_state_t  state;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;
   logic [4:0]  rd_q;

   logic        take_ld;
   logic        take_st;
   logic        accept;
   logic        bad;
   logic [31:0] wdata_lane;
   logic [3:0]  be_lane;
   logic [31:0] aligned;

   always_comb begin
      // A load request has priority whenever is_load is asserted.
      take_ld = is_load && ld_en;
      take_st = !is_load && is_store && st_en;
      accept  = (state == LSU_IDLE) && (take_ld || take_st);
      bad     = access_bad(take_ld, funct3, addr[1:0]);

      // Replicate store data across the word so the enabled lane carries it.
      case (funct3[1:0])
         2'b00: begin
            be_lane    = 4'b0001 << addr[1:0];
            wdata_lane = {4{st_data[7:0]}};
         end
         2'b01: begin
            be_lane    = 4'b0011 << addr[1:0];
            wdata_lane = {2{st_data[15:0]}};
         end
         default: begin
            be_lane    = 4'b1111;
            wdata_lane = st_data;
         end
      endcase
   end

   load_align u_load_align (
      .offset (off_q),
      .funct3 (f3_q),
      .word   (mem_resp_data),
      .data   (aligned)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= LSU_IDLE;
         busy          <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= 32'h0;
         mem_req_wdata <= 32'h0;
         mem_req_be    <= 4'h0;
         ld_valid      <= 1'b0;
         ld_rd         <= 5'h0;
         ld_data       <= 32'h0;
         access_fault  <= 1'b0;
         off_q         <= 2'h0;
         f3_q          <= 3'h0;
         rd_q          <= 5'h0;
      end else begin
         access_fault <= 1'b0;
         ld_valid     <= 1'b0;
         case (state)
            LSU_IDLE: begin
               if (accept) begin
                  if (bad) begin
                     access_fault <= 1'b1;
                  end else begin
                     state         <= LSU_REQ;
                     busy          <= 1'b1;
                     mem_req_valid <= 1'b1;
                     mem_req_we    <= take_st;
                     mem_req_addr  <= {addr[31:2], 2'b00};
                     mem_req_wdata <= take_st ? wdata_lane : 32'h0;
                     mem_req_be    <= be_lane;
                     off_q         <= addr[1:0];
                     f3_q          <= funct3;
                     rd_q          <= rd;
                  end
               end
            end
            LSU_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  if (mem_req_we) begin
                     state <= LSU_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= LSU_WAIT_RESP;
                  end
               end
            end
            LSU_WAIT_RESP: begin
               if (mem_resp_valid) begin
                  ld_data  <= aligned;
                  ld_rd    <= rd_q;
                  ld_valid <= 1'b1;
                  state    <= LSU_DONE;
               end
            end
            default: begin
               state <= LSU_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit. Stimulus pushes the
//               expected memory requests, load writebacks and faults; a
//               monitor pops and compares whenever the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ld_en = 1'b0, st_en = 1'b0, is_load = 1'b0, is_store = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] addr = 32'h0, st_data = 32'h0;
   logic [4:0]  rd = 5'd0;
   logic        busy, mem_req_valid, mem_req_we;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_be;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = 32'h0;
   logic        ld_valid, access_fault;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;

   load_store_unit dut (
      .clk(clk), .reset(reset), .ld_en(ld_en), .st_en(st_en),
      .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
      .st_data(st_data), .rd(rd), .busy(busy),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
      .access_fault(access_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } req_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   req_t req_q[$];
   wb_t  wb_q[$];
   int   fault_exp = 0;
   int   compared = 0;
   int   mismatched = 0;

   task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor: compares every cycle a request is presented (so the fields are
   // also checked for stability while stalled) and pops on handshake.
   always @(negedge clk) begin
      if (!reset) begin
         if (mem_req_valid) begin
            if (req_q.size() == 0) begin
               check("unexpected_req", {39'h0, mem_req_we, mem_req_addr}, 72'h0);
            end else if (req_q[0].we) begin
               check("store_req", {31'h0, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be},
                     {31'h0, req_q[0].we, req_q[0].addr, req_q[0].wdata, req_q[0].be});
               if (mem_req_ready) void'(req_q.pop_front());
            end else begin
               check("load_req", {39'h0, mem_req_we, mem_req_addr},
                     {39'h0, req_q[0].we, req_q[0].addr});
               if (mem_req_ready) void'(req_q.pop_front());
            end
         end
         if (ld_valid) begin
            if (wb_q.size() == 0) begin
               check("unexpected_ld_valid", {35'h0, ld_rd, ld_data}, 72'h0);
            end else begin
               check("load_wb", {35'h0, ld_rd, ld_data}, {35'h0, wb_q[0].rd, wb_q[0].data});
               void'(wb_q.pop_front());
            end
         end
         if (access_fault) begin
            if (fault_exp == 0) check("unexpected_fault", 72'h1, 72'h0);
            else begin
               check("fault", 72'h1, 72'h1);
               fault_exp--;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] r);
      is_load = ld; is_store = !ld; ld_en = 1'b1; st_en = 1'b1;
      funct3 = f3; addr = a; st_data = sd; rd = r;
      tick();
      is_load = 1'b0; is_store = 1'b0;
   endtask

   // Hold ready low for 'delay' REQ cycles; optionally poke a competing load
   // and a stray response while stalled, both of which must be ignored.
   task automatic handshake(input int delay, input bit poke);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (mem_req_valid) begin
            if (n >= delay) begin
               mem_req_ready = 1'b1;
               is_load = 1'b0;
               mem_resp_valid = 1'b0;
            end else begin
               mem_req_ready = 1'b0;
               if (poke) begin
                  is_load = 1'b1; ld_en = 1'b1; funct3 = 3'd2; addr = 32'h700; rd = 5'd31;
                  mem_resp_valid = 1'b1; mem_resp_data = 32'hBADBAD00;
               end
               check("stall_busy", {71'h0, busy}, 72'h1);
            end
            n++;
            tick();
         end else begin
            done = 1'b1;
         end
      end
      mem_req_ready = 1'b0;
      if (!done) check("handshake_timeout", 72'h0, 72'h1);
   endtask

   task automatic respond(input int waits, input logic [31:0] w);
      repeat (waits) tick();
      mem_resp_valid = 1'b1; mem_resp_data = w;
      tick();
      mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
      repeat (3) tick();
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] r,
                          input logic [31:0] w, input logic [31:0] exp, input int delay,
                          input int waits, input bit poke);
      req_q.push_back('{we: 1'b0, addr: {a[31:2], 2'b00}, wdata: 32'h0, be: 4'h0});
      wb_q.push_back('{rd: r, data: exp});
      issue(1'b1, f3, a, 32'h0, r);
      handshake(delay, poke);
      respond(waits, w);
   endtask

   task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wd,
                           input logic [3:0] exp_be);
      req_q.push_back('{we: 1'b1, addr: exp_addr, wdata: exp_wd, be: exp_be});
      issue(1'b0, f3, a, sd, 5'd0);
      handshake(0, 1'b0);
      repeat (3) tick();
   endtask

   task automatic do_fault(input bit ld, input logic [2:0] f3, input logic [31:0] a);
      fault_exp++;
      issue(ld, f3, a, 32'hFFFF_FFFF, 5'd7);
      check("fault_busy", {71'h0, busy}, 72'h0);
      repeat (3) tick();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"}, {71'h0, busy}, 72'h0);
      check({tag, "_ctl"}, {69'h0, mem_req_valid, ld_valid, access_fault}, 72'h0);
      check({tag, "_wb"}, {35'h0, ld_rd, ld_data}, 72'h0);
      check({tag, "_req"}, {31'h0, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be}, 72'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check_reset_state("reset_init");
      tick();
      reset = 1'b0;
      tick();

      // Word load, two wait cycles before the response.
      do_load(3'd2, 32'h100, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2, 1'b0);
      // Byte/half extraction and extension.
      do_load(3'd0, 32'h103, 5'd6, 32'h80FF00FF, 32'hFFFFFF80, 0, 0, 1'b0);
      do_load(3'd4, 32'h103, 5'd7, 32'h80FF00FF, 32'h00000080, 0, 0, 1'b0);
      do_load(3'd5, 32'h102, 5'd8, 32'h80FF00FF, 32'h000080FF, 0, 0, 1'b0);
      do_load(3'd1, 32'h102, 5'd9, 32'h80FF00FF, 32'hFFFF80FF, 0, 1, 1'b0);
      do_load(3'd1, 32'h100, 5'd10, 32'h12348765, 32'hFFFF8765, 0, 0, 1'b0);
      do_load(3'd0, 32'h101, 5'd11, 32'h80FF00FF, 32'h00000000, 0, 0, 1'b0);

      // Stores: lane replication and byte enables.
      do_store(3'd1, 32'h206, 32'h1234ABCD, 32'h204, 32'hABCDABCD, 4'b1100);
      do_store(3'd0, 32'h301, 32'h000000A5, 32'h300, 32'hA5A5A5A5, 4'b0010);
      do_store(3'd2, 32'h400, 32'hCAFEF00D, 32'h400, 32'hCAFEF00D, 4'b1111);

      // Misaligned and illegal accesses.
      do_fault(1'b1, 3'd2, 32'h101);
      do_fault(1'b0, 3'd1, 32'h203);
      do_fault(1'b1, 3'd3, 32'h100);
      do_fault(1'b0, 3'd4, 32'h200);

      // Request stalled five cycles with a competing load and stray response.
      do_load(3'd2, 32'h500, 5'd12, 32'h55AA55AA, 32'h55AA55AA, 5, 0, 1'b1);

      // Reset while waiting for a response; the late response is dropped.
      req_q.push_back('{we: 1'b0, addr: 32'h600, wdata: 32'h0, be: 4'h0});
      issue(1'b1, 3'd2, 32'h600, 32'h0, 5'd13);
      handshake(0, 1'b0);
      check("wait_busy", {71'h0, busy}, 72'h1);
      reset = 1'b1;
      #2;
      check_reset_state("reset_mid");
      tick();
      reset = 1'b0;
      tick();
      mem_resp_valid = 1'b1; mem_resp_data = 32'h11111111;
      tick();
      mem_resp_valid = 1'b0;
      repeat (4) tick();
      check("post_reset_ld", {70'h0, ld_valid, busy}, 72'h0);

      check("req_q_empty", 72'(req_q.size()), 72'h0);
      check("wb_q_empty", 72'(wb_q.size()), 72'h0);
      check("faults_seen", 72'(fault_exp), 72'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
